// File: rtl/div_pkg.sv
// Shared definitions for the sequential signed divider.
//   state_t  : controller states (IDLE, CALC, FIX)
//   MAX_W    : widest operand the magnitude helper supports
//   mag()    : two's-complement magnitude of a sign-extended operand
//   min_val()/max_val() : most negative / most positive value of a width
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam int MAX_W = 64;

  // Callers sign-extend their operand to MAX_W bits and truncate the result
  // back to their own width. The extra top bit keeps |MIN| representable.
  function automatic logic [MAX_W:0] mag(input logic [MAX_W-1:0] value);
    logic [MAX_W:0] ext;
    ext = {value[MAX_W-1], value};
    return ext[MAX_W] ? -ext : ext;
  endfunction

  function automatic logic [MAX_W-1:0] min_val(input int unsigned width);
    return MAX_W'(1) << (width - 1);
  endfunction

  function automatic logic [MAX_W-1:0] max_val(input int unsigned width);
    return (MAX_W'(1) << (width - 1)) - MAX_W'(1);
  endfunction

endpackage

// File: rtl/seq_signed_divider_div_step.sv
// One radix-2 restoring division iteration, purely combinational.
//   rem         : partial remainder entering the step
//   quo         : shift register (dividend bits out at the top, quotient
//                 bits in at the bottom)
//   divisor_mag : divisor magnitude
//   rem_next    : partial remainder after the step
//   quo_next    : shift register after the step
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH:0]   divisor_mag,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] shifted;
  logic           fits;

  // NOTE: every always_comb output is assigned on every path, so no latch
  // can be inferred.
  always_comb begin
    shifted  = {rem, quo[WIDTH-1]};
    fits     = (shifted >= divisor_mag);
    // After a subtraction the remainder is below the divisor magnitude, so
    // it always fits back into WIDTH bits.
    rem_next = fits ? WIDTH'(shifted - divisor_mag) : shifted[WIDTH-1:0];
    quo_next = {quo[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/seq_signed_divider.sv
// Multi-cycle signed integer divider: one quotient bit per clock.
// Ports:
//   clk, rst (synchronous, active-high)
//   start / dividend / divisor : request, operands sampled on accept
//   busy        : operation in progress
//   done        : one-cycle pulse, results valid
//   quotient    : truncated toward zero
//   remainder   : sign follows the dividend
//   div_by_zero : last result had divisor == 0
//   overflow    : last result was MIN / -1 (quotient saturated to MAX)
// Build option: SEQ_DIV_FAST_PATH_EN lets divisor 0/+1/-1 and dividend 0
// skip the iterations and finish one edge after accept.
module seq_signed_divider
  import div_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam logic [WIDTH-1:0] MIN_VAL  = WIDTH'(min_val(WIDTH));
  localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(max_val(WIDTH));
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] rem, quo, rem_next, quo_next;
  logic [WIDTH:0]   d_mag;
  logic             sign_a, sign_b, dz_pend, ov_pend;
  logic             accept, calc_en, fix_en;

  // |MIN| = 2^(WIDTH-1) still fits in WIDTH unsigned bits, which is all the
  // dividend shift register needs.
  logic [WIDTH-1:0] a_mag_in;
  logic [WIDTH:0]   d_mag_in;
  assign a_mag_in = WIDTH'(mag(MAX_W'($signed(dividend))));
  assign d_mag_in = (WIDTH + 1)'(mag(MAX_W'($signed(divisor))));
  assign accept   = start && (state == IDLE);

`ifdef SEQ_DIV_FAST_PATH_EN
  // The shift register already holds |dividend| and rem starts at zero, so
  // FIX produces the right answer for these cases without iterating.
  logic special;
  assign special = (d_mag_in == '0) || (d_mag_in == (WIDTH + 1)'(1)) ||
                   (dividend == '0);
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (start) begin
`ifdef SEQ_DIV_FAST_PATH_EN
          state_next = special ? FIX : CALC;
`else
          state_next = CALC;
`endif
        end
      end
      CALC:    if (count == LAST_CNT) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state != IDLE);
    calc_en = (state == CALC);
    fix_en  = (state == FIX);
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem        (rem),
    .quo        (quo),
    .divisor_mag(d_mag),
    .rem_next   (rem_next),
    .quo_next   (quo_next)
  );

  // NOTE: every register, internal ones included, is cleared by reset so an
  // aborted operation leaves nothing behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      count       <= '0;
      rem         <= '0;
      quo         <= '0;
      d_mag       <= '0;
      sign_a      <= 1'b0;
      sign_b      <= 1'b0;
      dz_pend     <= 1'b0;
      ov_pend     <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        count   <= '0;
        rem     <= '0;
        quo     <= a_mag_in;
        d_mag   <= d_mag_in;
        sign_a  <= dividend[WIDTH-1];
        sign_b  <= divisor[WIDTH-1];
        dz_pend <= (divisor == '0);
        ov_pend <= (dividend == MIN_VAL) && (divisor == '1);
      end
      if (calc_en) begin
        rem   <= rem_next;
        quo   <= quo_next;
        count <= count + CNT_W'(1);
      end
      if (fix_en) begin
        done        <= 1'b1;
        div_by_zero <= dz_pend;
        overflow    <= ov_pend;
        // A zero divisor leaves an all-ones quotient behind and MIN/-1 would
        // wrap, so both are overridden here.
        if (dz_pend) begin
          quotient  <= '0;
          remainder <= '0;
        end else if (ov_pend) begin
          quotient  <= MAX_VAL;
          remainder <= '0;
        end else begin
          quotient  <= (sign_a ^ sign_b) ? -quo : quo;
          remainder <= sign_a ? -rem : rem;
        end
      end
    end
  end

endmodule
